pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core. Drives en/clear of the IF/ID, ID/EX, EX/MEM and
//  MEM/WB pipeline registers, plus PC enable and PC source select. Resolves load-use, branch, data-memory wait,
//  instruction-fetch wait, and WB-stage trap/mret events. Times out hung data accesses as bus errors.
// PARAMETERS
//  MEM_TIMEOUT   255  max cycles in MEM_WAIT before bus-error trap; legal range 1..65535
//  FLUSH_CYCLES  1    extra cycles front stages are held cleared after trap/mret; legal range 1..15
// PORTS
//  clk_i          in   1   clock; all state on rising edge
//  rst_ni         in   1   asynchronous, active-low reset
//  rs1_id,rs2_id  in   5   source regs of instruction in ID
//  use_rs1_id,use_rs2_id  in  1  ID instruction actually reads rs1/rs2
//  rd_ex          in   5   dest reg in EX
//  is_load_ex     in   1   EX instruction is a load
//  branch_ex      in   1   EX resolved a taken branch/jump
//  imem_valid_i   in   1   fetch data valid this cycle
//  dmem_req_mem   in   1   MEM stage has an active data access
//  dmem_ack_i     in   1   data access completes this cycle
//  is_trap_wb     in   1   trap retiring in WB
//  is_mret_wb     in   1   mret retiring in WB
//  en_if_id,en_id_ex,en_ex_mem,en_mem_wb      out 1  register advance enables
//  clr_if_id,clr_id_ex,clr_ex_mem,clr_mem_wb  out 1  register bubble/flush (clear wins over en)
//  pc_en_o        out  1   PC register update enable
//  pc_sel_o       out  2   0 PC+4, 1 branch target, 2 trap vector (mtvec), 3 mepc
//  bus_err_o      out  1   one-cycle pulse: data access timed out, MEM stage must raise trap
//  stall_cnt_o    out  32  count of cycles with pc_en_o==0 (perf counter, wraps at 2^32)
// BEHAVIOUR
//  States: RST_HOLD, RUN, MEM_WAIT, FLUSH. State, timeout counter, flush counter, and stall_cnt_o are registered.
//  Asynchronous reset: state=RST_HOLD, counters=0, bus_err_o=0. Other outputs are combinational from state+inputs.
//  RST_HOLD (exactly 1 cycle after rst_ni rises): all clr=1, all en=0, pc_en=0, pc_sel=0; then RUN.
//  RUN default: all en=1, all clr=0, pc_en=1, pc_sel=0. Event priority, highest first:
//   1 trap/mret WB: clr_if_id=clr_id_ex=clr_ex_mem=clr_mem_wb=1; pc_en=1; pc_sel=2(trap) or 3(mret);
//     flush_cnt<=FLUSH_CYCLES; ->FLUSH. If trap and mret are both asserted, trap wins.
//   2 dmem_req_mem & !dmem_ack_i: en_if_id=en_id_ex=en_ex_mem=0, pc_en=0, clr_mem_wb=1 (bubble to WB);
//     tmo_cnt<=1; ->MEM_WAIT. A req with ack in the same cycle advances normally.
//   3 branch_ex: clr_if_id=clr_id_ex=1, pc_sel=1, pc_en=1 (load-use squashed).
//   4 load-use: is_load_ex & rd_ex!=0 & ((use_rs1_id&rs1_id==rd_ex)|(use_rs2_id&rs2_id==rd_ex)):
//     pc_en=0, en_if_id=0, clr_id_ex=1.
//   5 !imem_valid_i: pc_en=0, clr_if_id=1; downstream stages still advance.
//  MEM_WAIT: outputs as event 2. Checks, in order:
//   - trap/mret in WB: no effect; WB holds a bubble.
//   - dmem_ack_i=1: full advance this cycle (RUN defaults, with events 3-5 still applied); ->RUN.
//   - tmo_cnt==MEM_TIMEOUT w/o ack: bus_err_o=1 for this cycle; en_ex_mem=en_mem_wb=1 so the trapping
//     instruction reaches WB; ->RUN.
//   - otherwise: tmo_cnt++.
//  FLUSH: clr_if_id=clr_id_ex=clr_ex_mem=1, en_mem_wb=1, pc_en=1, pc_sel=0 (fetch from new PC);
//   flush_cnt-- each cycle; ->RUN when flush_cnt reaches 1. Ignores dmem/branch/load-use. A new trap in WB
//   restarts the flush (priority 1).
//  stall_cnt_o increments in any cycle with pc_en_o==0, including RST_HOLD.
//  Reset mid-operation: immediate return to RST_HOLD, and any pending access is abandoned (no bus_err_o).
// STRUCTURE
//  Package pipe_ctrl_pkg: state enum (2 bits), PC_SEL_* localparams (SEQ/BR/TRAP/MRET).
//  Sub-module mem_timeout_cnt: 16-bit load/increment/compare counter, outputs expired.
//  Remainder is one state register plus one always_comb output decoder.
// TESTING
//  Reset then idle: rst_ni 0->1, imem_valid=1 -> cycle 1 all clr=1, pc_en=0; cycle 2 all en=1, pc_en=1.
//  Load-use: is_load_ex=1, rd_ex=5, rs1_id=5, use_rs1=1 -> pc_en=0, en_if_id=0, clr_id_ex=1 for 1 cycle.
//   Same stimulus with rd_ex=0 -> no stall.
//  Mem wait: dmem_req=1, ack after 3 cycles -> 3 cycles of en_ex_mem=0, clr_mem_wb=1; advance on ack;
//   stall_cnt +3.
//  Timeout: MEM_TIMEOUT=4, dmem_req=1, no ack -> bus_err_o pulses in cycle 4 of MEM_WAIT; state then RUN.
//  Trap: is_trap_wb=1 together with branch_ex=1 and load-use -> pc_sel=2, all four clr=1;
//   FLUSH for FLUSH_CYCLES cycles. Trap+mret together -> pc_sel=2.
//  Branch during imem invalid: branch_ex=1, imem_valid=0 -> pc_sel=1, pc_en=1, clr_if_id=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and PC-select encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRstHold = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_TRAP = 2'd2;
  localparam logic [1:0] PC_SEL_MRET = 2'd3;

endpackage

// File: rtl/mem_timeout_cnt.sv
// 16-bit load/increment counter flagging when a data access has waited MEM_TIMEOUT cycles.
module mem_timeout_cnt #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 16'd1;
    end else if (inc_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 16'(MEM_TIMEOUT));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: pipeline register enables/clears, PC control,
// data-access timeout and stall-cycle performance counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        is_load_ex,
  input  logic        branch_ex,
  input  logic        imem_valid_i,
  input  logic        dmem_req_mem,
  input  logic        dmem_ack_i,
  input  logic        is_trap_wb,
  input  logic        is_mret_wb,
  output logic        en_if_id,
  output logic        en_id_ex,
  output logic        en_ex_mem,
  output logic        en_mem_wb,
  output logic        clr_if_id,
  output logic        clr_id_ex,
  output logic        clr_ex_mem,
  output logic        clr_mem_wb,
  output logic        pc_en_o,
  output logic [1:0]  pc_sel_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
);

  ctrl_state_e state_q, state_d;
  logic [3:0]  flush_q, flush_d;
  logic [31:0] stall_cnt_q;
  logic        tmo_load, tmo_inc, tmo_expired;
  logic        run_evt, load_use, wb_evt;

  mem_timeout_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (tmo_load),
    .inc_i    (tmo_inc),
    .expired_o(tmo_expired)
  );

  assign load_use = is_load_ex && (rd_ex != 5'd0) &&
                    ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));
  assign wb_evt   = is_trap_wb || is_mret_wb;

  always_comb begin
    en_if_id   = 1'b1;
    en_id_ex   = 1'b1;
    en_ex_mem  = 1'b1;
    en_mem_wb  = 1'b1;
    clr_if_id  = 1'b0;
    clr_id_ex  = 1'b0;
    clr_ex_mem = 1'b0;
    clr_mem_wb = 1'b0;
    pc_en_o    = 1'b1;
    pc_sel_o   = PC_SEL_SEQ;
    bus_err_o  = 1'b0;
    state_d    = state_q;
    flush_d    = flush_q;
    tmo_load   = 1'b0;
    tmo_inc    = 1'b0;
    run_evt    = 1'b0;

    unique case (state_q)
      StRstHold: begin
        {en_if_id, en_id_ex, en_ex_mem, en_mem_wb}     = 4'b0000;
        {clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb} = 4'b1111;
        pc_en_o = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        if (wb_evt) begin
          {clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb} = 4'b1111;
          pc_sel_o = is_trap_wb ? PC_SEL_TRAP : PC_SEL_MRET;
          flush_d  = 4'(FLUSH_CYCLES);
          state_d  = StFlush;
        end else if (dmem_req_mem && !dmem_ack_i) begin
          {en_if_id, en_id_ex, en_ex_mem} = 3'b000;
          pc_en_o    = 1'b0;
          clr_mem_wb = 1'b1;
          tmo_load   = 1'b1;
          state_d    = StMemWait;
        end else begin
          run_evt = 1'b1;
        end
      end
      StMemWait: begin
        // WB only ever holds a bubble here, so trap/mret inputs are not consulted.
        if (dmem_ack_i) begin
          run_evt = 1'b1;
          state_d = StRun;
        end else begin
          {en_if_id, en_id_ex, en_ex_mem} = 3'b000;
          pc_en_o    = 1'b0;
          clr_mem_wb = 1'b1;
          if (tmo_expired) begin
            bus_err_o  = 1'b1;
            en_ex_mem  = 1'b1;
            clr_mem_wb = 1'b0;
            state_d    = StRun;
          end else begin
            tmo_inc = 1'b1;
          end
        end
      end
      StFlush: begin
        if (wb_evt) begin
          {clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb} = 4'b1111;
          pc_sel_o = is_trap_wb ? PC_SEL_TRAP : PC_SEL_MRET;
          flush_d  = 4'(FLUSH_CYCLES);
        end else begin
          {clr_if_id, clr_id_ex, clr_ex_mem} = 3'b111;
          flush_d = flush_q - 4'd1;
          if (flush_q <= 4'd1) begin
            state_d = StRun;
          end
        end
      end
    endcase

    // Lower-priority hazards: only the highest one present takes effect.
    if (run_evt) begin
      if (branch_ex) begin
        clr_if_id = 1'b1;
        clr_id_ex = 1'b1;
        pc_sel_o  = PC_SEL_BR;
      end else if (load_use) begin
        pc_en_o   = 1'b0;
        en_if_id  = 1'b0;
        clr_id_ex = 1'b1;
      end else if (!imem_valid_i) begin
        pc_en_o   = 1'b0;
        clr_if_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRstHold;
      flush_q     <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_q + {31'd0, ~pc_en_o};
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT=4, FLUSH_CYCLES=2).
module tb_pipeline_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        use_rs1_id, use_rs2_id, is_load_ex, branch_ex, imem_valid_i;
  logic        dmem_req_mem, dmem_ack_i, is_trap_wb, is_mret_wb;
  logic        en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic        clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb;
  logic        pc_en_o, bus_err_o;
  logic [1:0]  pc_sel_o;
  logic [31:0] stall_cnt_o;
  logic [11:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected control words: {en[if,id,ex,mem], clr[if,id,ex,mem], pc_en, pc_sel, bus_err}
  localparam logic [11:0] C_HOLD   = 12'h0F0;
  localparam logic [11:0] C_RUN    = 12'hF08;
  localparam logic [11:0] C_LDUSE  = 12'h740;
  localparam logic [11:0] C_MSTALL = 12'h110;
  localparam logic [11:0] C_TMO    = 12'h301;
  localparam logic [11:0] C_TRAP   = 12'hFFC;
  localparam logic [11:0] C_MRET   = 12'hFFE;
  localparam logic [11:0] C_FLUSH  = 12'hFE8;
  localparam logic [11:0] C_BR     = 12'hFCA;
  localparam logic [11:0] C_IMISS  = 12'hF80;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(
    .MEM_TIMEOUT (4),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .use_rs1_id  (use_rs1_id),
    .use_rs2_id  (use_rs2_id),
    .rd_ex       (rd_ex),
    .is_load_ex  (is_load_ex),
    .branch_ex   (branch_ex),
    .imem_valid_i(imem_valid_i),
    .dmem_req_mem(dmem_req_mem),
    .dmem_ack_i  (dmem_ack_i),
    .is_trap_wb  (is_trap_wb),
    .is_mret_wb  (is_mret_wb),
    .en_if_id    (en_if_id),
    .en_id_ex    (en_id_ex),
    .en_ex_mem   (en_ex_mem),
    .en_mem_wb   (en_mem_wb),
    .clr_if_id   (clr_if_id),
    .clr_id_ex   (clr_id_ex),
    .clr_ex_mem  (clr_ex_mem),
    .clr_mem_wb  (clr_mem_wb),
    .pc_en_o     (pc_en_o),
    .pc_sel_o    (pc_sel_o),
    .bus_err_o   (bus_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  assign ctl = {en_if_id, en_id_ex, en_ex_mem, en_mem_wb, clr_if_id, clr_id_ex, clr_ex_mem,
                clr_mem_wb, pc_en_o, pc_sel_o, bus_err_o};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; is_load_ex = 1'b0; branch_ex = 1'b0;
    imem_valid_i = 1'b1; dmem_req_mem = 1'b0; dmem_ack_i = 1'b0;
    is_trap_wb = 1'b0; is_mret_wb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    check_eq("reset_ctl", 32'(ctl), 32'(C_HOLD));
    cyc(); cyc();
    check_eq("reset_stall", stall_cnt_o, 32'd0);
    rst_ni = 1'b1;
    #1;
    check_eq("rst_hold", 32'(ctl), 32'(C_HOLD));
    cyc();
    check_eq("run_idle", 32'(ctl), 32'(C_RUN));
    check_eq("stall_after_hold", stall_cnt_o, 32'd1);

    // Load-use via rs1, then rd=x0, then via rs2, then rs2 not used
    is_load_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1'b1;
    #1; check_eq("lduse_rs1", 32'(ctl), 32'(C_LDUSE));
    cyc();
    rd_ex = 5'd0; rs1_id = 5'd0;
    #1; check_eq("lduse_x0", 32'(ctl), 32'(C_RUN));
    use_rs1_id = 1'b0; rd_ex = 5'd7; rs2_id = 5'd7; use_rs2_id = 1'b1;
    #1; check_eq("lduse_rs2", 32'(ctl), 32'(C_LDUSE));
    cyc();
    use_rs2_id = 1'b0;
    #1; check_eq("lduse_unused", 32'(ctl), 32'(C_RUN));
    check_eq("stall_lduse", stall_cnt_o, 32'd3);
    idle_inputs();

    // Data-memory wait, ack after 3 stall cycles; trap in WB is ignored while waiting
    dmem_req_mem = 1'b1;
    #1; check_eq("mwait_enter", 32'(ctl), 32'(C_MSTALL));
    cyc();
    is_trap_wb = 1'b1;
    #1; check_eq("mwait_trap_ign", 32'(ctl), 32'(C_MSTALL));
    cyc();
    is_trap_wb = 1'b0;
    #1; check_eq("mwait_3", 32'(ctl), 32'(C_MSTALL));
    cyc();
    dmem_ack_i = 1'b1;
    #1; check_eq("mwait_ack", 32'(ctl), 32'(C_RUN));
    cyc();
    #1; check_eq("req_ack_same", 32'(ctl), 32'(C_RUN));
    cyc();
    idle_inputs();
    #1; check_eq("after_mwait", 32'(ctl), 32'(C_RUN));
    check_eq("stall_mwait", stall_cnt_o, 32'd6);

    // Timeout: RUN entry cycle then MEM_WAIT cycles 1..4, bus error on 4th
    dmem_req_mem = 1'b1;
    #1; check_eq("tmo_enter", 32'(ctl), 32'(C_MSTALL));
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_eq("tmo_wait", 32'(ctl), 32'(C_MSTALL));
    end
    cyc();
    check_eq("tmo_buserr", 32'(ctl), 32'(C_TMO));
    cyc();
    dmem_req_mem = 1'b0;
    #1; check_eq("tmo_back_run", 32'(ctl), 32'(C_RUN));
    check_eq("stall_tmo", stall_cnt_o, 32'd11);

    // Trap beats branch and load-use; flush lasts 2 cycles and ignores dmem
    is_trap_wb = 1'b1; branch_ex = 1'b1; is_load_ex = 1'b1;
    rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1'b1;
    #1; check_eq("trap_prio", 32'(ctl), 32'(C_TRAP));
    cyc();
    idle_inputs();
    dmem_req_mem = 1'b1;
    #1; check_eq("flush_1", 32'(ctl), 32'(C_FLUSH));
    cyc();
    dmem_req_mem = 1'b0;
    #1; check_eq("flush_2", 32'(ctl), 32'(C_FLUSH));
    cyc();
    check_eq("flush_done", 32'(ctl), 32'(C_RUN));

    // Trap+mret -> trap vector; mret during flush restarts it
    is_trap_wb = 1'b1; is_mret_wb = 1'b1;
    #1; check_eq("trap_mret", 32'(ctl), 32'(C_TRAP));
    cyc();
    is_trap_wb = 1'b0;
    #1; check_eq("flush_mret", 32'(ctl), 32'(C_MRET));
    cyc();
    is_mret_wb = 1'b0;
    #1; check_eq("reflush_1", 32'(ctl), 32'(C_FLUSH));
    cyc();
    check_eq("reflush_2", 32'(ctl), 32'(C_FLUSH));
    cyc();
    check_eq("reflush_done", 32'(ctl), 32'(C_RUN));

    // Branch during fetch miss, then plain fetch miss
    branch_ex = 1'b1; imem_valid_i = 1'b0;
    #1; check_eq("br_imiss", 32'(ctl), 32'(C_BR));
    cyc();
    branch_ex = 1'b0;
    #1; check_eq("imiss", 32'(ctl), 32'(C_IMISS));
    cyc();
    imem_valid_i = 1'b1;
    #1; check_eq("stall_imiss", stall_cnt_o, 32'd12);

    // Reset mid wait: back to hold, counter cleared, no bus error
    dmem_req_mem = 1'b1;
    cyc(); cyc(); cyc();
    check_eq("pre_reset_wait", 32'(ctl), 32'(C_MSTALL));
    rst_ni = 1'b0;
    #1; check_eq("midreset_ctl", 32'(ctl), 32'(C_HOLD));
    check_eq("midreset_stall", stall_cnt_o, 32'd0);
    cyc();
    dmem_req_mem = 1'b0;
    rst_ni = 1'b1;
    #1; check_eq("midreset_hold", 32'(ctl), 32'(C_HOLD));
    cyc();
    check_eq("midreset_run", 32'(ctl), 32'(C_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
